// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int XLEN = 16;
    localparam logic [XLEN-1:0] INSTR_NOP = 16'h0800;

    typedef enum logic {
        IF_S_REQ  = 1'b0,
        IF_S_HOLD = 1'b1
    } if_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_ctl_e;

    // Wraps silently from 16'hFFFF to 16'h0000.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/ifetch_if_id_reg.sv
// IF/ID pipeline register: address, instruction and valid with load/hold/flush control.
module ifetch_if_id_reg
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  ifid_ctl_e       ctl_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] addr_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            case (ctl_i)
                IFID_LOAD: begin
                    addr_q  <= addr_i;
                    instr_q <= instr_i;
                    valid_q <= 1'b1;
                end
                IFID_FLUSH: begin
                    addr_q  <= '0;
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
                default: begin
                    addr_q  <= addr_q;
                    instr_q <= instr_q;
                    valid_q <= valid_q;
                end
            endcase
        end
    end

    assign addr_o  = addr_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a ready
// handshake and feeds the IF/ID register, handling redirects, stalls and port contention.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET   = 16'h0000,
    parameter logic [XLEN-1:0] INT_VECTOR = 16'h0008,
    parameter logic [XLEN-1:0] NOP_INSTR  = INSTR_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifi_branch,
    input  logic [XLEN-1:0] ifi_new_pc,
    input  logic            ifi_interrupt,
    input  logic            ifi_stall,
    input  logic            ifi_mem_busy,
    input  logic [XLEN-1:0] ifi_mem_data,
    input  logic            ifi_mem_ready,
    output logic [XLEN-1:0] ifo_mem_addr,
    output logic            ifo_mem_re,
    output logic [XLEN-1:0] ifo_addr,
    output logic [XLEN-1:0] ifo_instr,
    output logic            ifo_valid
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            redir_pend_q, redir_pend_d;
    logic            rst_rel_q;

    logic            req;
    logic            ready_eff;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    ifid_ctl_e       ifid_ctl;
    logic [XLEN-1:0] ifid_instr;

    // Ready only counts when a request was actually issued this cycle.
    assign req         = (state_q == IF_S_REQ) && !ifi_mem_busy && !rst_rel_q;
    assign ready_eff   = req && ifi_mem_ready;
    assign redirect    = ifi_interrupt || ifi_branch;
    assign redirect_pc = ifi_interrupt ? INT_VECTOR : ifi_new_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IF_S_REQ;
            pc_q         <= PC_RESET;
            buf_q        <= '0;
            redir_pend_q <= 1'b0;
            rst_rel_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_pend_q <= redir_pend_d;
            rst_rel_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_pend_d = redir_pend_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = IF_S_REQ;
            // A read left hanging at the old PC must have its completion dropped.
            redir_pend_d = (redir_pend_q || req) && !ready_eff;
        end else if (state_q == IF_S_HOLD) begin
            if (!ifi_stall) begin
                pc_d    = pc_inc(pc_q);
                state_d = IF_S_REQ;
            end
        end else if (ready_eff) begin
            if (redir_pend_q) begin
                redir_pend_d = 1'b0;
            end else if (ifi_stall) begin
                buf_d   = ifi_mem_data;
                state_d = IF_S_HOLD;
            end else begin
                pc_d = pc_inc(pc_q);
            end
        end
    end

    always_comb begin
        ifid_ctl   = IFID_HOLD;
        ifid_instr = ifi_mem_data;
        if (redirect) begin
            ifid_ctl = IFID_FLUSH;
        end else if (state_q == IF_S_HOLD) begin
            if (!ifi_stall) begin
                ifid_ctl   = IFID_LOAD;
                ifid_instr = buf_q;
            end
        end else if (ifi_stall) begin
            ifid_ctl = IFID_HOLD;
        end else if (ready_eff && !redir_pend_q) begin
            ifid_ctl = IFID_LOAD;
        end else begin
            ifid_ctl = IFID_FLUSH;
        end
    end

    assign ifo_mem_addr = pc_q;
    assign ifo_mem_re   = req;

    ifetch_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .ctl_i   (ifid_ctl),
        .addr_i  (pc_inc(pc_q)),
        .instr_i (ifid_instr),
        .addr_o  (ifo_addr),
        .instr_o (ifo_instr),
        .valid_o (ifo_valid)
    );

endmodule
